// File: rtl/datapath_pkg.sv
// Purpose: shared opcodes, sequencer state encoding, flag bit indices and
//          instruction field-offset helpers for the multicycle datapath.
// Latency: n/a (declarations only). Backpressure: n/a.
package datapath_pkg;

  localparam int OPCODE_WIDTH = 5;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 5'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 5'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 5'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 5'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = 5'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 5'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_BZ   = 5'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  // Flag vector is {N,Z,C,V}.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Field layout, MSB down: opcode, rs, rd; imm sits in the low bits.
  function automatic int op_lsb(input int instr_w);
    return instr_w - OPCODE_WIDTH;
  endfunction

  function automatic int rs_lsb(input int instr_w, input int reg_aw);
    return instr_w - OPCODE_WIDTH - reg_aw;
  endfunction

  function automatic int rd_lsb(input int instr_w, input int reg_aw);
    return instr_w - OPCODE_WIDTH - 2 * reg_aw;
  endfunction

  function automatic logic is_alu_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op <= OP_BZ) || (op == OP_HALT);
  endfunction

  function automatic logic writes_rd(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LDI) || is_alu_op(op) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational ALU (ADD/SUB/AND/OR/XOR) producing result and next {N,Z,C,V}.
// Latency: 0 cycles, purely combinational. Backpressure: none.
// Ports: i_op opcode, i_a = R[rd], i_b = R[rs]; o_result, o_flags {N,Z,C,V}.
module alu_core
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 36
) (
  input  logic [OPCODE_WIDTH-1:0] i_op,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic [DATA_WIDTH-1:0]   o_result,
  output logic [3:0]              o_flags
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_c;
  logic                  w_v;

  // One extra bit catches carry-out on ADD and borrow (a < b unsigned) on SUB.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (i_a[MSB] == i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[DATA_WIDTH];
        w_v   = (i_a[MSB] != i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      default: w_res = '0;
    endcase
  end

  assign o_result        = w_res;
  assign o_flags[FLAG_N] = w_res[MSB];
  assign o_flags[FLAG_Z] = (w_res == '0);
  assign o_flags[FLAG_C] = w_c;
  assign o_flags[FLAG_V] = w_v;

endmodule

// File: rtl/multicycle_datapath.sv
// Purpose: multicycle CPU core: fetch, decode, execute, writeback sequencer with regfile and flags.
// Latency: 4 cycles per instruction when imem_valid arrives in the first FETCH cycle.
// Backpressure: FETCH holds imem_req high and waits indefinitely for imem_valid.
// Ports: clk, reset (async active-low); imem_req/imem_addr/imem_valid/imem_data fetch
//        handshake; pc, flags {N,Z,C,V}, halted, sticky illegal; dbg_addr -> dbg_data.
// Option: IMM_SEXT_EN sign-extends imm and makes JMP/BZ pc-relative.
module multicycle_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH     = 36,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH      = 8,
  parameter int PC_WIDTH       = 16,
  parameter int INSTR_WIDTH    = 36
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [PC_WIDTH-1:0]       imem_addr,
  input  logic                      imem_valid,
  input  logic [INSTR_WIDTH-1:0]    imem_data,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [3:0]                flags,
  output logic                      halted,
  output logic                      illegal,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int OP_LSB   = op_lsb(INSTR_WIDTH);
  localparam int RS_LSB   = rs_lsb(INSTR_WIDTH, REG_ADDR_WIDTH);
  localparam int RD_LSB   = rd_lsb(INSTR_WIDTH, REG_ADDR_WIDTH);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [PC_WIDTH-1:0]         r_pc;
  logic [INSTR_WIDTH-1:0]      r_ir;
  logic [DATA_WIDTH-1:0]       r_a;
  logic [DATA_WIDTH-1:0]       r_b;
  logic [DATA_WIDTH-1:0]       r_res;
  logic [3:0]                  r_flags;
  logic                        r_illegal;
  logic [DATA_WIDTH-1:0]       r_regs [NUM_REGS];

  logic [OPCODE_WIDTH-1:0]     w_op;
  logic [REG_ADDR_WIDTH-1:0]   w_rs;
  logic [REG_ADDR_WIDTH-1:0]   w_rd;
  logic [IMM_WIDTH-1:0]        w_imm;
  logic [DATA_WIDTH-1:0]       w_imm_data;
  logic [PC_WIDTH+IMM_WIDTH-1:0] w_imm_pc_wide;
  logic [PC_WIDTH-1:0]         w_jmp_target;
  logic [PC_WIDTH-1:0]         w_pc_nxt;
  logic [DATA_WIDTH-1:0]       w_exec_res;
  logic [DATA_WIDTH-1:0]       w_alu_res;
  logic [3:0]                  w_alu_flags;
  logic                        w_unused;

  assign w_op  = r_ir[OP_LSB +: OPCODE_WIDTH];
  assign w_rs  = r_ir[RS_LSB +: REG_ADDR_WIDTH];
  assign w_rd  = r_ir[RD_LSB +: REG_ADDR_WIDTH];
  assign w_imm = r_ir[IMM_WIDTH-1:0];

  // The wide pc-extension lets one expression cover both PC_WIDTH > IMM_WIDTH
  // (extend) and PC_WIDTH < IMM_WIDTH (truncate); only the low PC_WIDTH bits matter.
`ifdef IMM_SEXT_EN
  assign w_imm_data    = {{(DATA_WIDTH-IMM_WIDTH){w_imm[IMM_WIDTH-1]}}, w_imm};
  assign w_imm_pc_wide = {{PC_WIDTH{w_imm[IMM_WIDTH-1]}}, w_imm};
  assign w_jmp_target  = r_pc + w_imm_pc_wide[PC_WIDTH-1:0];
`else
  assign w_imm_data    = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, w_imm};
  assign w_imm_pc_wide = {{PC_WIDTH{1'b0}}, w_imm};
  assign w_jmp_target  = w_imm_pc_wide[PC_WIDTH-1:0];
`endif

  // Padding bits between rd and imm, and the high extension bits, carry no meaning.
  assign w_unused = ^{r_ir, w_imm_pc_wide};

  alu_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu_core (
    .i_op     (w_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

  always_comb begin
    w_exec_res = w_alu_res;
    case (w_op)
      OP_LDI:  w_exec_res = w_imm_data;
      OP_MOV:  w_exec_res = r_b;
      default: w_exec_res = w_alu_res;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc + PC_WIDTH'(1);
    case (w_op)
      OP_JMP:  w_pc_nxt = w_jmp_target;
      OP_BZ:   if (r_flags[FLAG_Z]) w_pc_nxt = w_jmp_target;
      OP_HALT: w_pc_nxt = r_pc;
      default: w_pc_nxt = r_pc + PC_WIDTH'(1);
    endcase
  end

  // Sequencer: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer: next state and control outputs.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) w_state_nxt = ST_DECODE;
      end
      ST_DECODE:    w_state_nxt = ST_EXECUTE;
      ST_EXECUTE:   w_state_nxt = ST_WRITEBACK;
      ST_WRITEBACK: w_state_nxt = (w_op == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:      halted      = 1'b1;
      default:      w_state_nxt = ST_FETCH;
    endcase
  end

  // Datapath state, updated phase by phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_valid) r_ir <= imem_data;
        end
        ST_DECODE: begin
          r_a <= (w_rd == '0) ? '0 : r_regs[w_rd];
          r_b <= (w_rs == '0) ? '0 : r_regs[w_rs];
        end
        ST_EXECUTE: begin
          r_res <= w_exec_res;
          if (is_alu_op(w_op)) r_flags <= w_alu_flags;
          if (!is_legal_op(w_op)) r_illegal <= 1'b1;
        end
        ST_WRITEBACK: begin
          if (writes_rd(w_op) && (w_rd != '0)) r_regs[w_rd] <= r_res;
          r_pc <= w_pc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign flags     = r_flags;
  assign illegal   = r_illegal;
  // Register reads see the pre-write value in a writeback cycle.
  assign dbg_data  = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
Parametrised multicycle datapath with its own control FSM, program counter, flags register and instruction-memory handshake. Contents:
- instruction register, decoder, register file, ALU, immediate/ALU write mux, sequencer.
Fetches one instruction word per request and executes it in four phases. Used as the CPU core instance below the top level.

Parameters:
DATA_WIDTH, 36, register/ALU width; DATA_WIDTH >= IMM_WIDTH+1.
REG_ADDR_WIDTH, 5, register index width; depth = 2**REG_ADDR_WIDTH.
IMM_WIDTH, 8, immediate field width.
PC_WIDTH, 16, program counter width.
INSTR_WIDTH, 36, instruction word width; INSTR_WIDTH >= 5+2*REG_ADDR_WIDTH+IMM_WIDTH.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
imem_req  out  1  fetch request.
imem_addr  out  PC_WIDTH  fetch address (equals pc).
imem_valid  in  1  imem_data valid this cycle.
imem_data  in  INSTR_WIDTH  instruction word.
pc  out  PC_WIDTH  current program counter.
flags  out  4  {N,Z,C,V}.
halted  out  1  high in HALT state.
illegal  out  1  sticky: undefined opcode executed.
dbg_addr  in  REG_ADDR_WIDTH  debug register select.
dbg_data  out  DATA_WIDTH  combinational R[dbg_addr].

Behaviour:
- Instruction fields, MSB down: opcode[5], rs, rd; imm = low IMM_WIDTH bits.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd <= zero-extended imm.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: rd <= R[rd] op R[rs].
  - 7 MOV: rd <= R[rs].
  - 8 JMP: pc <= imm zero-extended or truncated to PC_WIDTH.
  - 9 BZ: jump if Z=1, else pc+1.
  - 31 HALT.
  - Any other opcode: NOP that sets illegal.
- FSM states FETCH, DECODE, EXECUTE, WRITEBACK, HALT:
  - FETCH: imem_req=1. On imem_valid, IR <= imem_data, go DECODE. Otherwise wait indefinitely.
  - DECODE: latch A=R[rd], B=R[rs]. 1 cycle.
  - EXECUTE: latch ALU result into RES. ALU ops (2-6) update flags; all other opcodes leave flags unchanged. 1 cycle.
  - WRITEBACK: write RES into rd for LDI/ALU/MOV. pc <= pc+1, or the jump target for JMP/taken BZ. Go to FETCH, or HALT if opcode=31; pc is not incremented on HALT.
  - HALT: absorbing; only reset leaves it.
- Latency: 4 cycles per instruction when imem_valid is returned in the first FETCH cycle.
- imem_valid outside FETCH is ignored.
- R0 reads 0; writes to R0 are discarded.
- Flags:
  - Z = result==0; N = result MSB.
  - ADD: C = carry-out, V = signed overflow.
  - SUB: C = borrow (R[rd] < R[rs] unsigned), V = signed overflow.
  - Logic ops: C=0, V=0.
- pc wraps modulo 2**PC_WIDTH; 0xFFFF+1 = 0 at default width.
- Reset (any cycle, mid-instruction included) forces: state=FETCH, pc=0, IR=0, A=B=RES=0, flags=0, illegal=0, all registers 0. Therefore imem_req=1, halted=0 while reset is asserted.
- A same-cycle read and write of one register in the debug port returns the old value.

Optional Feature:
IMM_SEXT_EN:
- Defined: LDI, JMP and BZ sign-extend imm to the destination width. JMP/BZ then add the extended imm to pc (relative branch, modulo wrap).
- Undefined: zero-extend, absolute target as above.

Decomposition:
- Shared package (datapath_pkg): opcode constants, FSM state encoding, flag bit indices, field-offset functions derived from the parameters.
- One natural sub-module: alu_core. It is combinational, parametrised by DATA_WIDTH, and outputs result plus next N/Z/C/V.
- Register file, IR and sequencer stay inline.

Test Plan:
- Reset mid-EXECUTE of ADD -> next cycle: pc=0, flags=0, imem_req=1, R[rd] unchanged from 0.
- LDI R1,0xFF; LDI R2,0x01; ADD R1,R2 with imem_valid immediate -> R1=0x100, Z=0 C=0. Each instruction takes 4 cycles; pc=3 after third.
- LDI R3,5; SUB R3,R3 -> R3=0, Z=1, C=0; BZ 0x20 -> pc=0x20. Repeat with Z=0 -> pc=previous+1.
- R1=0x7FFFFFFFF, R2=1, ADD R1,R2 -> R1=0x800000000, N=1, V=1, C=0. R1=0xFFFFFFFFF plus 1 -> 0, C=1, Z=1.
- imem_valid withheld 7 cycles in FETCH -> IR and pc unchanged, imem_req held high; imem_valid pulses in DECODE are ignored.
- Opcode 12 -> illegal=1, registers and flags unchanged. HALT -> halted=1, imem_req=0 permanently, pc frozen until reset. JMP from pc 0xFFFF with no jump -> NOP at 0xFFFF wraps pc to 0.
